// File: rtl/sps_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : sps_pkg
//  Purpose  : Shared types and helpers for the sps_deser serial deserialiser.
//  Revision : 1.0 - initial release
// ============================================================================
package sps_pkg;

    // Frame-capture FSM states; PARITY is only reachable with SPS_PARITY_EN
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        PARITY = 2'd2
    } sps_state_t;

    // Bit count width able to hold 0..width inclusive
    function automatic int sps_cnt_w(input int width);
        return $clog2(width + 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/sps_shifter.sv
`default_nettype none
// ============================================================================
//  Module   : sps_shifter
//  Purpose  : WIDTH-bit capture register; writes one serial bit at a frame
//             index, with bit order chosen by MSB_FIRST. A restart clears the
//             partially captured word before bit 0 is written.
//  Revision : 1.0 - initial release
// ============================================================================
module sps_shifter #(
    parameter int WIDTH     = 8,
    parameter int MSB_FIRST = 0,
    parameter int CW        = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_load,
    input  logic             i_restart,
    input  logic [CW-1:0]    i_idx,
    input  logic             i_din,
    output logic [WIDTH-1:0] o_q,
    output logic [WIDTH-1:0] o_q_nxt
);

    logic [WIDTH-1:0] r_q;
    logic [WIDTH-1:0] w_base;
    logic [CW-1:0]    w_pos;

    // Map frame index to physical bit position
    generate
        if (MSB_FIRST != 0) begin : g_msb_first
            assign w_pos = CW'(WIDTH - 1) - i_idx;
        end else begin : g_lsb_first
            assign w_pos = i_idx;
        end
    endgenerate

    // Next register value: optional clear, then write the incoming bit
    always_comb begin
        w_base  = i_restart ? '0 : r_q;
        o_q_nxt = w_base;
        if (i_load) begin
            for (int i = 0; i < WIDTH; i++) begin
                if (w_pos == CW'(i)) begin
                    o_q_nxt[i] = i_din;
                end
            end
        end
    end

    // Capture register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_q <= '0;
        end else begin
            r_q <= o_q_nxt;
        end
    end

    assign o_q = r_q;

endmodule
`default_nettype wire

// File: rtl/sps_deser.sv
`default_nettype none
// ============================================================================
//  Module   : sps_deser
//  Purpose  : Framed serial-to-parallel deserialiser with valid/ack holding
//             register, overrun pulse and optional parity check.
//  Options  : define SPS_PARITY_EN to append a parity bit to each frame.
//  Revision : 1.0 - initial release
// ============================================================================
module sps_deser
    import sps_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int MSB_FIRST = 0,
    parameter int PAR_ODD   = 0
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             bit_en,
    input  logic             start,
    input  logic             datai,
    input  logic             ack,
    output logic [WIDTH-1:0] datao,
    output logic             wr,
    output logic             ovr,
    output logic             par_err
);

    localparam int CW = sps_cnt_w(WIDTH);
    localparam logic [CW-1:0] c_last = CW'(WIDTH - 1);

    sps_state_t       r_state;
    logic [CW-1:0]    r_cnt;

    logic             w_restart;
    logic             w_load;
    logic [CW-1:0]    w_idx;
    logic             w_last;
    logic             w_done;
    logic [WIDTH-1:0] w_word;
    logic             w_perr;
    logic [WIDTH-1:0] w_q;
    logic [WIDTH-1:0] w_q_nxt;
    logic             w_unused;

    // A start bit always begins a new frame; data bits only land while shifting
    assign w_restart = bit_en & start;
    assign w_load    = w_restart | (bit_en & (r_state == SHIFT));
    assign w_idx     = w_restart ? '0 : r_cnt;
    assign w_last    = bit_en & ~start & (r_state == SHIFT) & (r_cnt == c_last);

`ifdef SPS_PARITY_EN
    // Word completes on the parity bit; data already sits in the capture reg
    assign w_done = bit_en & ~start & (r_state == PARITY);
    assign w_word = w_q;
    assign w_perr = (^{w_q, datai}) ^ PAR_ODD[0];
`else
    // Word completes on the last data bit, which is still in flight
    assign w_done = w_last;
    assign w_word = w_q_nxt;
    assign w_perr = 1'b0;
`endif

    // Sink for values only one build variant consumes
    assign w_unused = ^{w_q, w_q_nxt, PAR_ODD[0]};

    sps_shifter #(
        .WIDTH     (WIDTH),
        .MSB_FIRST (MSB_FIRST),
        .CW        (CW)
    ) u_shifter (
        .clk       (clk),
        .rst       (clr),
        .i_load    (w_load),
        .i_restart (w_restart),
        .i_idx     (w_idx),
        .i_din     (datai),
        .o_q       (w_q),
        .o_q_nxt   (w_q_nxt)
    );

    // Frame FSM and bit counter
    always_ff @(posedge clk) begin
        if (clr) begin
            r_state <= IDLE;
            r_cnt   <= '0;
        end else if (bit_en) begin
            if (start) begin
                r_state <= SHIFT;
                r_cnt   <= CW'(1);
            end else begin
                case (r_state)
                    SHIFT: begin
                        if (r_cnt != CW'(WIDTH)) begin
                            r_cnt <= r_cnt + CW'(1);
                        end
                        if (w_last) begin
`ifdef SPS_PARITY_EN
                            r_state <= PARITY;
`else
                            r_state <= IDLE;
`endif
                        end
                    end
                    PARITY:  r_state <= IDLE;
                    default: r_state <= IDLE;
                endcase
            end
        end
    end

    // Holding register with valid/ack handshake and overrun detection
    always_ff @(posedge clk) begin
        if (clr) begin
            datao   <= '0;
            wr      <= 1'b0;
            ovr     <= 1'b0;
            par_err <= 1'b0;
        end else begin
            ovr <= 1'b0;
            if (w_done) begin
                if (!wr || ack) begin
                    datao   <= w_word;
                    par_err <= w_perr;
                    wr      <= 1'b1;
                end else begin
                    ovr <= 1'b1;
                end
            end else if (wr && ack) begin
                wr <= 1'b0;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_sps_deser.sv
`default_nettype none
// ============================================================================
//  Module   : tb_sps_deser
//  Purpose  : Self-checking bench for sps_deser; one LSB-first and one
//             MSB-first instance share the serial stimulus.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_sps_deser;

    logic       clk = 1'b0;
    logic       clr = 1'b1;
    logic       bit_en = 1'b0;
    logic       start = 1'b0;
    logic       datai = 1'b0;
    logic       ack = 1'b0;

    logic [7:0] datao0, datao1;
    logic       wr0, wr1, ovr0, ovr1, perr0, perr1;

    int         total = 0;
    int         bad = 0;

    logic [7:0] exp_q0[$];
    logic [7:0] exp_q1[$];

    always #5 clk = ~clk;

    sps_deser #(.WIDTH(8), .MSB_FIRST(0), .PAR_ODD(0)) dut0 (
        .clk(clk), .clr(clr), .bit_en(bit_en), .start(start), .datai(datai), .ack(ack),
        .datao(datao0), .wr(wr0), .ovr(ovr0), .par_err(perr0)
    );

    sps_deser #(.WIDTH(8), .MSB_FIRST(1), .PAR_ODD(0)) dut1 (
        .clk(clk), .clr(clr), .bit_en(bit_en), .start(start), .datai(datai), .ack(ack),
        .datao(datao1), .wr(wr1), .ovr(ovr1), .par_err(perr1)
    );

    // Word as assembled from a transmission-ordered bit sequence
    function automatic logic [7:0] model(input logic [7:0] seq, input bit msb);
        logic [7:0] r;
        for (int i = 0; i < 8; i++) begin
            r[msb ? 7 - i : i] = seq[i];
        end
        return r;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // One serial bit, preceded by gap idle cycles with noise on start/datai
    task automatic send_bit(input logic b, input logic st, input int gap, input logic a);
        repeat (gap) begin
            @(negedge clk);
            bit_en = 1'b0;
            start  = 1'b1;
            datai  = 1'($urandom);
        end
        @(negedge clk);
        bit_en = 1'b1;
        start  = st;
        datai  = b;
        ack    = a;
        @(posedge clk);
    endtask

    // Full frame; a_last is ack during the completing bit, par < 0 sends correct parity
    task automatic send_frame(input logic [7:0] seq, input int gap, input bit push,
                              input logic a_body, input logic a_last, input int par);
        for (int i = 0; i < 8; i++) begin
`ifdef SPS_PARITY_EN
            send_bit(seq[i], i == 0, gap, a_body);
`else
            send_bit(seq[i], i == 0, gap, (i == 7) ? a_last : a_body);
`endif
        end
`ifdef SPS_PARITY_EN
        send_bit((par < 0) ? ^seq : 1'(par), 1'b0, gap, a_last);
`else
        if (par > 1) $display("note: parity value unused");
`endif
        if (push) begin
            exp_q0.push_back(model(seq, 1'b0));
            exp_q1.push_back(model(seq, 1'b1));
        end
    endtask

    // Negedge right after the completing edge: go idle, then compare
    task automatic idle_edge(input logic a);
        @(negedge clk);
        bit_en = 1'b0;
        start  = 1'b0;
        ack    = a;
    endtask

    task automatic expect_word(input string tag, input logic exp_perr);
        logic [7:0] e0, e1;
        chk({tag, "_wr0"}, wr0, 1);
        chk({tag, "_wr1"}, wr1, 1);
        if (exp_q0.size() == 0 || exp_q1.size() == 0) begin
            total++;
            bad++;
            $error("FAIL %s_queue observed=empty expected=word", tag);
        end else begin
            e0 = exp_q0.pop_front();
            e1 = exp_q1.pop_front();
            chk({tag, "_d0"}, datao0, e0);
            chk({tag, "_d1"}, datao1, e1);
        end
        chk({tag, "_perr0"}, perr0, exp_perr);
        chk({tag, "_perr1"}, perr1, exp_perr);
    endtask

    initial begin
        // Reset
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_wr", wr0, 0);
        chk("rst_d0", datao0, 0);
        chk("rst_d1", datao1, 0);
        chk("rst_ovr", ovr0, 0);
        chk("rst_perr", perr0, 0);
        clr = 1'b0;

        // Back-to-back 0xA5 with ack held high: wr one cycle after last bit
        send_frame(8'hA5, 0, 1, 1'b1, 1'b1, -1);
        idle_edge(1'b1);
        expect_word("a5", 1'b0);
        chk("a5_ovr", ovr0, 0);
        @(negedge clk);
        chk("a5_ack_clr", wr0, 0);

        // Same word with 3-cycle gaps between bits
        send_frame(8'hA5, 3, 1, 1'b1, 1'b1, -1);
        idle_edge(1'b1);
        expect_word("a5gap", 1'b0);
        @(negedge clk);
        chk("a5gap_ack_clr", wr1, 0);

        // Overrun: 0x3C held, 0xC3 dropped
        send_frame(8'h3C, 0, 1, 1'b0, 1'b0, -1);
        idle_edge(1'b0);
        expect_word("ov1", 1'b0);
        send_frame(8'hC3, 0, 0, 1'b0, 1'b0, -1);
        idle_edge(1'b0);
        chk("ov_pulse0", ovr0, 1);
        chk("ov_pulse1", ovr1, 1);
        chk("ov_hold0", datao0, 8'h3C);
        chk("ov_wr", wr0, 1);
        @(negedge clk);
        chk("ov_one_cycle", ovr0, 0);
        chk("ov_wr_held", wr0, 1);
        ack = 1'b1;
        @(negedge clk);
        chk("ov_ack_clr", wr0, 0);

        // Restart mid-frame: partial bits discarded
        send_bit(1'b0, 1'b1, 0, 1'b1);
        send_bit(1'b0, 1'b0, 0, 1'b1);
        send_bit(1'b1, 1'b0, 0, 1'b1);
        send_bit(1'b0, 1'b0, 0, 1'b1);
        send_frame(8'hFF, 0, 1, 1'b1, 1'b1, -1);
        idle_edge(1'b1);
        expect_word("restart", 1'b0);
        chk("restart_ovr", ovr0, 0);

        // Completion on the same edge as ack: new word replaces old, no overrun
        send_frame(8'h5A, 0, 1, 1'b0, 1'b0, -1);
        idle_edge(1'b0);
        expect_word("same1", 1'b0);
        send_frame(8'h96, 0, 1, 1'b0, 1'b1, -1);
        idle_edge(1'b0);
        expect_word("same2", 1'b0);
        chk("same_ovr", ovr0, 0);
        ack = 1'b1;
        @(negedge clk);
        chk("same_ack_clr", wr0, 0);

        // Synchronous clear mid-frame
        send_frame(8'h11, 0, 1, 1'b0, 1'b0, -1);
        idle_edge(1'b0);
        expect_word("clr_pre", 1'b0);
        send_bit(1'b1, 1'b1, 0, 1'b0);
        send_bit(1'b1, 1'b0, 0, 1'b0);
        send_bit(1'b1, 1'b0, 0, 1'b0);
        @(negedge clk);
        bit_en = 1'b0;
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        chk("clr_wr", wr0, 0);
        chk("clr_d0", datao0, 0);
        chk("clr_d1", datao1, 0);
        for (int i = 0; i < 9; i++) begin
            send_bit(1'b1, 1'b0, 0, 1'b0);
        end
        idle_edge(1'b0);
        chk("clr_nostart_wr0", wr0, 0);
        chk("clr_nostart_wr1", wr1, 0);
        send_frame(8'h81, 0, 1, 1'b1, 1'b1, -1);
        idle_edge(1'b1);
        expect_word("clr_post", 1'b0);

`ifdef SPS_PARITY_EN
        // Even parity: 0x07 with parity 1 is good, with parity 0 is bad
        send_frame(8'h07, 0, 1, 1'b1, 1'b1, 1);
        idle_edge(1'b1);
        expect_word("par_ok", 1'b0);
        send_frame(8'h07, 0, 1, 1'b1, 1'b1, 0);
        idle_edge(1'b1);
        expect_word("par_bad", 1'b1);
`endif

        @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
